// File: rtl/branch_sequencer.sv
// Fetch-address sequencer: increments pc, evaluates conditional jumps and
// redirects fetch with a one-cycle flush pulse when a branch is taken.
module branch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_ready,
   input  logic             br_valid,
   input  logic [1:0]       br_op,
   input  logic [15:0]      br_pc,
   input  logic [15:0]      cmp_a,
   input  logic [15:0]      cmp_b,
   input  logic [15:0]      br_offset,
   output logic [15:0]      pc,
   output logic             pc_valid,
   output logic             br_ready,
   output logic             flush,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      EVAL  = 2'd1,
      REDIR = 2'd2
   } state_t;

   state_t           state_r;
   logic [15:0]      pc_r;
   logic             pc_valid_r;
   logic             br_ready_r;
   logic             flush_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       op_r;
   logic [15:0]      bpc_r;
   logic [15:0]      a_r;
   logic [15:0]      b_r;
   logic [15:0]      off_r;
   logic             taken_s;
   logic [15:0]      target_s;
   logic             accept_s;

   assign accept_s = br_ready_r & br_valid & (br_op != 2'b00);
   assign target_s = bpc_r + 16'd1 + off_r;

   // Branch decision from the operands captured at acceptance.
   always_comb begin
      taken_s = 1'b0;
      case (op_r)
         2'b01:   taken_s = 1'b1;
         2'b10:   taken_s = (a_r < b_r);
         2'b11:   taken_s = ($signed(a_r) < $signed(b_r));
         default: taken_s = 1'b0;
      endcase
   end

   // Sequencer FSM; pc_valid/br_ready are registered and lag reset release by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= RUN;
         pc_r       <= RESET_PC;
         pc_valid_r <= 1'b0;
         br_ready_r <= 1'b0;
         flush_r    <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
         op_r       <= 2'b00;
         bpc_r      <= 16'h0000;
         a_r        <= 16'h0000;
         b_r        <= 16'h0000;
         off_r      <= 16'h0000;
      end else begin
         flush_r <= 1'b0;
         case (state_r)
            RUN: begin
               if (accept_s) begin
                  op_r       <= br_op;
                  bpc_r      <= br_pc;
                  a_r        <= cmp_a;
                  b_r        <= cmp_b;
                  off_r      <= br_offset;
                  state_r    <= EVAL;
                  pc_valid_r <= 1'b0;
                  br_ready_r <= 1'b0;
               end else begin
                  pc_valid_r <= 1'b1;
                  br_ready_r <= 1'b1;
                  // pc only advances once fetch has actually seen a valid address
                  if (pc_valid_r && fetch_ready) begin
                     pc_r <= pc_r + 16'd1;
                  end else begin
                     pc_r <= pc_r;
                  end
               end
            end
            EVAL: begin
               if (taken_s) begin
                  state_r <= REDIR;
                  flush_r <= 1'b1;
               end else begin
                  state_r    <= RUN;
                  pc_valid_r <= 1'b1;
                  br_ready_r <= 1'b1;
               end
            end
            REDIR: begin
               // target load and count happen on leaving REDIR so a reset here abandons both
               pc_r       <= target_s;
               state_r    <= RUN;
               pc_valid_r <= 1'b1;
               br_ready_r <= 1'b1;
               if (cnt_r != {CNT_W{1'b1}}) begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            default: begin
               state_r    <= RUN;
               pc_valid_r <= 1'b0;
               br_ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign pc        = pc_r;
   assign pc_valid  = pc_valid_r;
   assign br_ready  = br_ready_r;
   assign flush     = flush_r;
   assign taken_cnt = cnt_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer (default parameters).
module tb_branch_sequencer;

   logic        clk;
   logic        rst;
   logic        fetch_ready;
   logic        br_valid;
   logic [1:0]  br_op;
   logic [15:0] br_pc;
   logic [15:0] cmp_a;
   logic [15:0] cmp_b;
   logic [15:0] br_offset;
   logic [15:0] pc;
   logic        pc_valid;
   logic        br_ready;
   logic        flush;
   logic [7:0]  taken_cnt;

   int n_cmp;
   int n_err;

   branch_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_ready(fetch_ready),
      .br_valid   (br_valid),
      .br_op      (br_op),
      .br_pc      (br_pc),
      .cmp_a      (cmp_a),
      .cmp_b      (cmp_b),
      .br_offset  (br_offset),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .br_ready   (br_ready),
      .flush      (flush),
      .taken_cnt  (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_br(input logic [1:0] op, input logic [15:0] bpc, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] off);
      br_valid  = 1'b1;
      br_op     = op;
      br_pc     = bpc;
      cmp_a     = a;
      cmp_b     = b;
      br_offset = off;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      fetch_ready = 1'b0;
      br_valid    = 1'b0;
      br_op       = 2'b00;
      br_pc       = 16'h0000;
      cmp_a       = 16'h0000;
      cmp_b       = 16'h0000;
      br_offset   = 16'h0000;
      step();
      step();
      check("rst_pc", 32'(pc), 32'h0000);
      check("rst_pc_valid", 32'(pc_valid), 32'h0);
      check("rst_br_ready", 32'(br_ready), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_cnt", 32'(taken_cnt), 32'h00);

      // first cycle after reset release
      rst = 1'b0;
      step();
      check("post_rst_pc_valid", 32'(pc_valid), 32'h1);
      check("post_rst_br_ready", 32'(br_ready), 32'h1);
      check("seq_pc0", 32'(pc), 32'h0000);
      fetch_ready = 1'b1;
      step();
      check("seq_pc1", 32'(pc), 32'h0001);
      step();
      check("seq_pc2", 32'(pc), 32'h0002);
      step();
      check("seq_pc3", 32'(pc), 32'h0003);
      check("seq_valid", 32'(pc_valid), 32'h1);

      // unsigned less-than taken, fetch_ready high on accept cycle
      set_br(2'b10, 16'h0010, 16'h0003, 16'h0005, 16'h0004);
      step();
      check("ltu_eval_pc_hold", 32'(pc), 32'h0003);
      check("ltu_eval_valid", 32'(pc_valid), 32'h0);
      check("ltu_eval_ready", 32'(br_ready), 32'h0);
      check("ltu_eval_flush", 32'(flush), 32'h0);
      br_valid = 1'b0;
      step();
      check("ltu_redir_flush", 32'(flush), 32'h1);
      check("ltu_redir_valid", 32'(pc_valid), 32'h0);
      step();
      check("ltu_run_pc", 32'(pc), 32'h0015);
      check("ltu_run_valid", 32'(pc_valid), 32'h1);
      check("ltu_run_flush", 32'(flush), 32'h0);
      check("ltu_cnt", 32'(taken_cnt), 32'h01);

      // signed less-than: FFFF (-1) < 0001 -> taken, target 0020+1+0010
      fetch_ready = 1'b0;
      set_br(2'b11, 16'h0020, 16'hFFFF, 16'h0001, 16'h0010);
      step();
      br_valid = 1'b0;
      step();
      check("lts_redir_flush", 32'(flush), 32'h1);
      step();
      check("lts_pc", 32'(pc), 32'h0031);
      check("lts_cnt", 32'(taken_cnt), 32'h02);

      // unsigned compare of the same operands -> not taken
      set_br(2'b10, 16'h0020, 16'hFFFF, 16'h0001, 16'h0010);
      step();
      check("ltu_nt_eval_valid", 32'(pc_valid), 32'h0);
      check("ltu_nt_eval_flush", 32'(flush), 32'h0);
      br_valid = 1'b0;
      step();
      check("ltu_nt_pc", 32'(pc), 32'h0031);
      check("ltu_nt_valid", 32'(pc_valid), 32'h1);
      check("ltu_nt_flush", 32'(flush), 32'h0);
      check("ltu_nt_cnt", 32'(taken_cnt), 32'h02);

      // op 00 is ignored and sequential fetch continues
      set_br(2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
      fetch_ready = 1'b1;
      step();
      check("op00_pc", 32'(pc), 32'h0032);
      check("op00_valid", 32'(pc_valid), 32'h1);
      br_valid    = 1'b0;
      fetch_ready = 1'b0;

      // jump with wrap: 0002 + 1 + FFFD = 0000
      set_br(2'b01, 16'h0002, 16'h0000, 16'h0000, 16'hFFFD);
      step();
      br_valid = 1'b0;
      step();
      step();
      check("jmp_wrap_pc", 32'(pc), 32'h0000);
      check("jmp_wrap_cnt", 32'(taken_cnt), 32'h03);

      // jump to FFFF, then increment wraps to 0000
      set_br(2'b01, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE);
      step();
      br_valid = 1'b0;
      step();
      step();
      check("jmp_ffff_pc", 32'(pc), 32'h0000FFFF);
      fetch_ready = 1'b1;
      step();
      check("inc_wrap_pc", 32'(pc), 32'h0000);
      fetch_ready = 1'b0;

      // 300 back-to-back jumps with br_valid held: counter saturates
      set_br(2'b01, 16'h0002, 16'h0000, 16'h0000, 16'hFFFD);
      for (int i = 0; i < 300; i++) begin
         step();
         step();
         step();
      end
      br_valid = 1'b0;
      check("sat_cnt", 32'(taken_cnt), 32'h000000FF);
      check("sat_pc", 32'(pc), 32'h0000);
      check("sat_valid", 32'(pc_valid), 32'h1);

      // reset during EVAL abandons the branch
      fetch_ready = 1'b1;
      step();
      check("pre_rst_pc", 32'(pc), 32'h0001);
      fetch_ready = 1'b0;
      set_br(2'b01, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
      step();
      check("rst_eval_state_valid", 32'(pc_valid), 32'h0);
      br_valid = 1'b0;
      rst      = 1'b1;
      step();
      check("rst_eval_pc", 32'(pc), 32'h0000);
      check("rst_eval_flush", 32'(flush), 32'h0);
      check("rst_eval_cnt", 32'(taken_cnt), 32'h00);
      rst = 1'b0;
      step();
      check("rst_eval_after_flush", 32'(flush), 32'h0);
      check("rst_eval_after_pc", 32'(pc), 32'h0000);
      check("rst_eval_after_valid", 32'(pc_valid), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
